store_byte_writer: RTL and testbench

Memory-side responder for RV32I store instructions (SB/SH/SW). It accepts one store request per handshake from the control unit's S-type path: funct3, effective address and rs2 data. It serializes the request into little-endian byte writes on a byte-wide data-memory port and reports completion or a misalignment/illegal-width error with a one-cycle response pulse. It sits between the execute stage and data memory.

---
 rtl/store_byte_writer.sv | 122 ++++++++++++
 tb/tb_store_byte_writer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_byte_writer.sv
// Store byte writer: accepts one SB/SH/SW request and writes it to a byte-wide memory port
// in little-endian order, then pulses done (with err on misaligned or illegal width).
module store_byte_writer #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StWrite, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            k_q, k_d;
  logic                  err_q, err_d;

  logic                  req_legal;
  logic [1:0]            req_last;

  // Width decode: req_last is the index of the final byte (N-1).
  always_comb begin
    req_legal = 1'b0;
    req_last  = 2'd0;
    case (req_funct3)
      3'b000: begin
        req_legal = 1'b1;
        req_last  = 2'd0;
      end
      3'b001: begin
        req_legal = ~req_addr[0];
        req_last  = 2'd1;
      end
      3'b010: begin
        req_legal = (req_addr[1:0] == 2'b00);
        req_last  = 2'd3;
      end
      default: begin
        req_legal = 1'b0;
        req_last  = 2'd0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    k_d     = k_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          last_d  = req_last;
          k_d     = 2'd0;
          err_d   = ~req_legal;
          state_d = req_legal ? StWrite : StResp;
        end
      end
      StWrite: begin
        if (mem_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == last_q) begin
            err_d   = 1'b0;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 2'd0;
      k_q     <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state and captured registers only; address and data are
  // forced to zero outside WRITE so the port is quiet when idle or in reset.
  always_comb begin
    mem_we    = (state_q == StWrite);
    mem_addr  = mem_we ? (addr_q + ADDR_WIDTH'(k_q)) : '0;
    mem_wdata = mem_we ? data_q[{k_q, 3'b000} +: 8] : 8'h00;
    done      = (state_q == StResp);
    err       = done & err_q;
    req_ready = (state_q == StIdle) & rst_n;
  end

endmodule

// File: tb/tb_store_byte_writer.sv
// Bench for store_byte_writer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed byte/cycle expectations and a randomized phase.
module tb_store_byte_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b1;
  logic        done;
  logic        err;

  store_byte_writer #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // mem_ready: random, or high except inside a scheduled stall window.
  bit rnd_mr = 1'b0;
  int stall_lo = -1;
  int stall_hi = -2;
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mr) mem_ready = ($urandom_range(0, 3) != 0);
    else        mem_ready = !(cyc >= stall_lo && cyc <= stall_hi);
  end

  // Reference model: pending byte writes in order, then one response.
  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t m_q[$];
  bit  m_resp = 1'b0;
  bit  m_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_resp = 1'b0;
      m_err  = 1'b0;
    end else if (m_q.size() > 0) begin
      if (mem_ready) void'(m_q.pop_front());
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (req_valid) begin
      int n;
      bit legal;
      n = (req_funct3 == 3'd0) ? 1 : (req_funct3 == 3'd1) ? 2 : (req_funct3 == 3'd2) ? 4 : 0;
      legal = (n != 0) && ((req_addr % n) == 0);
      if (legal) begin
        for (int i = 0; i < n; i++) begin
          wr_t w;
          w.a = req_addr + i;
          w.d = 8'((req_data >> (8 * i)) & 32'hFF);
          m_q.push_back(w);
        end
      end
      m_resp = 1'b1;
      m_err  = !legal;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic        e_we, e_done, e_err, e_rdy;
    logic [31:0] e_addr;
    logic [7:0]  e_data;
    @(negedge clk);
    e_we = 0; e_done = 0; e_err = 0; e_rdy = 0; e_addr = 0; e_data = 0;
    if (rst_n) begin
      if (m_q.size() > 0) begin
        e_we   = 1;
        e_addr = m_q[0].a;
        e_data = m_q[0].d;
      end else if (m_resp) begin
        e_done = 1;
        e_err  = m_err;
      end else begin
        e_rdy = 1;
      end
    end
    chk("model_mem_we", 64'(mem_we), 64'(e_we));
    chk("model_mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("model_mem_wdata", 64'(mem_wdata), 64'(e_data));
    chk("model_done", 64'(done), 64'(e_done));
    chk("model_err", 64'(err), 64'(e_err));
    chk("model_req_ready", 64'(req_ready), 64'(e_rdy));
  end

  // Observation log for directed literal checks.
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          c;
  } log_t;
  log_t        wlog[$];
  int          dcnt = 0;
  int          hold_cnt = 0;
  logic [31:0] hold_addr = 32'hFFFF_FFFF;
  logic [7:0]  hold_data = 8'h00;

  initial forever begin
    @(negedge clk);
    if (rst_n && mem_we && mem_ready) begin
      log_t l;
      l.a = mem_addr;
      l.d = mem_wdata;
      l.c = cyc;
      wlog.push_back(l);
    end
    if (rst_n && mem_we && mem_addr == hold_addr && mem_wdata == hold_data) hold_cnt++;
    if (done) dcnt++;
  end

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                      input bit keep, output int acc);
    req_funct3 = f;
    req_addr   = a;
    req_data   = d;
    req_valid  = 1'b1;
    acc        = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] a,
                           input logic [7:0] d, input int c);
    if (idx < wlog.size()) begin
      chk({name, "_addr"}, 64'(wlog[idx].a), 64'(a));
      chk({name, "_data"}, 64'(wlog[idx].d), 64'(d));
      chk({name, "_cyc"}, 64'(wlog[idx].c), 64'(c));
    end else begin
      chk({name, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    int a, a2, dc, d0;
    logic [7:0] sw_bytes [4];
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;

    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SW 0x100 / 0xDEADBEEF, mem_ready high
    wlog.delete();
    send(3'b010, 32'h100, 32'hDEADBEEF, 1'b0, a);
    wait_done(dc);
    chk("sw_done_cyc", 64'(dc), 64'(a + 5));
    chk("sw_err", 64'(err), 64'd0);
    @(negedge clk);
    chk("sw_ready_back", 64'(req_ready), 64'd1);
    chk("sw_nbytes", 64'(wlog.size()), 64'd4);
    for (int k = 0; k < 4; k++) check_log("sw_byte", k, 32'h100 + k, sw_bytes[k], a + 1 + k);
    @(posedge clk);
    #1;

    // SB 0x203 and SH 0x202
    wlog.delete();
    send(3'b000, 32'h203, 32'h12345678, 1'b0, a);
    wait_done(dc);
    chk("sb_done_cyc", 64'(dc), 64'(a + 2));
    chk("sb_nbytes", 64'(wlog.size()), 64'd1);
    check_log("sb_byte", 0, 32'h203, 8'h78, a + 1);
    @(posedge clk);
    #1;
    wlog.delete();
    send(3'b001, 32'h202, 32'h0000ABCD, 1'b0, a);
    wait_done(dc);
    chk("sh_done_cyc", 64'(dc), 64'(a + 3));
    chk("sh_nbytes", 64'(wlog.size()), 64'd2);
    check_log("sh_b0", 0, 32'h202, 8'hCD, a + 1);
    check_log("sh_b1", 1, 32'h203, 8'hAB, a + 2);
    @(posedge clk);
    #1;

    // Error requests: misaligned SH, misaligned SW, illegal funct3
    for (int t = 0; t < 3; t++) begin
      logic [2:0]  f;
      logic [31:0] ad;
      f  = (t == 0) ? 3'b001 : (t == 1) ? 3'b010 : 3'b011;
      ad = (t == 0) ? 32'h101 : (t == 1) ? 32'h102 : 32'h100;
      wlog.delete();
      send(f, ad, 32'hCAFEF00D, 1'b0, a);
      wait_done(dc);
      chk("err_done_cyc", 64'(dc), 64'(a + 1));
      chk("err_flag", 64'(err), 64'd1);
      @(negedge clk);
      chk("err_no_writes", 64'(wlog.size()), 64'd0);
      @(posedge clk);
      #1;
    end

    // SW with mem_ready low in cycles 2-3; req_data changed after acceptance
    wlog.delete();
    hold_cnt  = 0;
    hold_addr = 32'h101;
    hold_data = 8'hBE;
    send(3'b010, 32'h100, 32'hDEADBEEF, 1'b0, a);
    stall_lo = cyc + 1;
    stall_hi = cyc + 2;
    req_data = 32'h0;
    wait_done(dc);
    chk("stall_done_cyc", 64'(dc), 64'(a + 7));
    chk("stall_hold_cycles", 64'(hold_cnt), 64'd3);
    chk("stall_nbytes", 64'(wlog.size()), 64'd4);
    check_log("stall_b0", 0, 32'h100, 8'hEF, a + 1);
    check_log("stall_b1", 1, 32'h101, 8'hBE, a + 4);
    check_log("stall_b2", 2, 32'h102, 8'hAD, a + 5);
    check_log("stall_b3", 3, 32'h103, 8'hDE, a + 6);
    stall_lo  = -1;
    stall_hi  = -2;
    hold_addr = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;

    // Reset in cycle 2 of an SW, then an SB completes normally
    send(3'b010, 32'h300, 32'h11223344, 1'b0, a);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_done_err", 64'({done, err}), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    d0 = dcnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(dcnt), 64'(d0));
    wlog.delete();
    send(3'b000, 32'h203, 32'h12345678, 1'b0, a);
    wait_done(dc);
    chk("post_rst_sb_done", 64'(dc), 64'(a + 2));
    check_log("post_rst_sb", 0, 32'h203, 8'h78, a + 1);
    @(posedge clk);
    #1;

    // Back-to-back with req_valid held high
    wlog.delete();
    send(3'b010, 32'h400, 32'hA1B2C3D4, 1'b1, a);
    send(3'b001, 32'h40A, 32'h00005566, 1'b0, a2);
    chk("b2b_accept_gap", 64'(a2), 64'(a + 6));
    wait_done(dc);
    chk("b2b_done_cyc", 64'(dc), 64'(a2 + 3));
    chk("b2b_nbytes", 64'(wlog.size()), 64'd6);
    check_log("b2b_b0", 0, 32'h400, 8'hD4, a + 1);
    check_log("b2b_b3", 3, 32'h403, 8'hA1, a + 4);
    check_log("b2b_b4", 4, 32'h40A, 8'h66, a2 + 1);
    check_log("b2b_b5", 5, 32'h40B, 8'h55, a2 + 2);
    @(posedge clk);
    #1;

    // Randomized phase: model comparison runs every cycle
    rnd_mr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int          r, gap;
      logic [2:0]  f;
      logic [31:0] ad;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        req_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      r  = $urandom_range(0, 9);
      f  = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f == 3'b001) ad[0] = 1'b0;
        if (f == 3'b010) ad[1:0] = 2'b00;
      end
      send(f, ad, $urandom, 1'b1, a);
    end
    req_valid = 1'b0;
    rnd_mr    = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 64'(req_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
